// File: rtl/denise_serializer_pkg.sv
// Shared encodings and helpers for the Denise multi-plane playfield serializer:
// fetch-mode masks, resolution decode, shift-enable and scroll-field extraction.
package denise_serializer_pkg;

  localparam logic [1:0] FMODE_16  = 2'b00;
  localparam logic [1:0] FMODE_32A = 2'b01;
  localparam logic [1:0] FMODE_32B = 2'b10;
  localparam logic [1:0] FMODE_64  = 2'b11;

  localparam int SCROLLER_W = 64;

  typedef enum logic [1:0] {
    LORES = 2'd0,
    HIRES = 2'd1,
    SHRES = 2'd2
  } res_t;

  function automatic logic [5:0] scroll_mask(input logic [1:0] fmode);
    logic [5:0] m;
    case (fmode)
      FMODE_16: m = 6'h0F;
      FMODE_64: m = 6'h3F;
      default:  m = 6'h1F;
    endcase
    return m;
  endfunction

  function automatic logic [6:0] active_width(input logic [1:0] fmode);
    logic [6:0] w;
    case (fmode)
      FMODE_16: w = 7'd16;
      FMODE_64: w = 7'd64;
      default:  w = 7'd32;
    endcase
    return w;
  endfunction

  function automatic res_t decode_res(input logic hires, input logic shres);
    res_t r;
    if (shres)      r = SHRES;
    else if (hires) r = HIRES;
    else            r = LORES;
    return r;
  endfunction

  // Lores shifts once per bus slot, hires twice, super-hires on every pixel clock.
  function automatic logic shift_en(input res_t res, input logic c1, input logic c3);
    logic s;
    case (res)
      SHRES:   s = 1'b1;
      HIRES:   s = ~c1 ^ c3;
      default: s = ~c1 & ~c3;
    endcase
    return s;
  endfunction

  function automatic logic [5:0] scroll_field(input res_t res, input logic [7:0] scroll);
    logic [5:0] f;
    case (res)
      SHRES:   f = scroll[5:0];
      HIRES:   f = scroll[6:1];
      default: f = scroll[7:2];
    endcase
    return f;
  endfunction

  function automatic logic [5:0] scroll_select(input res_t res, input logic [7:0] scroll,
                                               input logic [1:0] fmode);
    return scroll_field(res, scroll) & scroll_mask(fmode);
  endfunction

endpackage

// File: rtl/denise_playfield_serializer_lane.sv
// One bitplane lane: holding register, load/shift register, 64-bit scroll
// history, scroll tap mux and the output delay line.
module denise_plane_lane
  import denise_serializer_pkg::*;
#(
  parameter int FETCH_W   = 64,
  parameter int OUT_DELAY = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [FETCH_W-1:0] i_wr_data,
  input  logic               i_load,
  input  logic [FETCH_W-1:0] i_load_mask,
  input  logic               i_shift,
  input  logic [5:0]         i_select,
  output logic               o_pix
);

  logic [FETCH_W-1:0]    r_hold;
  logic [FETCH_W-1:0]    r_shifter;
  logic [SCROLLER_W-1:0] r_scroller;
  logic [OUT_DELAY-1:0]  r_delay;
  logic                  w_tap;

  assign w_tap = r_scroller[i_select];
  assign o_pix = r_delay[OUT_DELAY-1];

  // The scroller keeps taking the outgoing MSB even on a load cycle, so the
  // last bit of the previous fetch is not lost when a transfer lands on a shift.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hold     <= '0;
      r_shifter  <= '0;
      r_scroller <= '0;
      r_delay    <= '0;
    end else begin
      if (i_wr) r_hold <= i_wr_data;
      if (i_load)       r_shifter <= r_hold & i_load_mask;
      else if (i_shift) r_shifter <= {r_shifter[FETCH_W-2:0], 1'b0};
      if (i_shift) r_scroller <= {r_scroller[SCROLLER_W-2:0], r_shifter[FETCH_W-1]};
      r_delay[0] <= w_tap;
      for (int i = 1; i < OUT_DELAY; i++) r_delay[i] <= r_delay[i-1];
    end
  end

endmodule

// File: rtl/denise_playfield_serializer.sv
// Multi-plane Denise playfield serializer: arm/transfer control and shift decode
// around PLANES lanes. DENISE_SERIALIZER_ODD_EVEN_SCROLL_EN enables separate even-plane scroll.
module denise_playfield_serializer
  import denise_serializer_pkg::*;
#(
  parameter int PLANES    = 8,
  parameter int FETCH_W   = 64,
  parameter int OUT_DELAY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c1,
  input  logic               c3,
  input  logic               hires,
  input  logic               shres,
  input  logic [1:0]         fmode,
  input  logic               wr_en,
  input  logic [2:0]         wr_plane,
  input  logic [FETCH_W-1:0] wr_data,
  input  logic [7:0]         scroll_odd,
  input  logic [7:0]         scroll_even,
  output logic               load_pending,
  output logic [PLANES-1:0]  pix_out
);

  localparam logic [3:0] PLANES_L = 4'(PLANES);

  res_t               w_res;
  logic               w_slot;
  logic               w_shift;
  logic               w_transfer;
  logic               w_wr_valid;
  logic               w_wr_plane0;
  logic [5:0]         w_sel_odd;
  logic [5:0]         w_sel_even;
  logic [6:0]         w_width;
  logic [FETCH_W-1:0] w_load_mask;
  logic               r_arm;

  assign w_res       = decode_res(hires, shres);
  assign w_slot      = !c1 && !c3;
  assign w_shift     = shift_en(w_res, c1, c3);
  assign w_transfer  = r_arm && w_slot;
  assign w_wr_valid  = wr_en && ({1'b0, wr_plane} < PLANES_L);
  assign w_wr_plane0 = w_wr_valid && (wr_plane == 3'd0);
  assign w_sel_odd   = scroll_select(w_res, scroll_odd, fmode);

`ifdef DENISE_SERIALIZER_ODD_EVEN_SCROLL_EN
  assign w_sel_even = scroll_select(w_res, scroll_even, fmode);
`else
  logic w_unused_scroll_even;
  assign w_unused_scroll_even = ^scroll_even;
  assign w_sel_even = w_sel_odd;
`endif

  // Active fetch width keeps the top bits; it saturates at the physical width.
  always_comb begin
    w_width = active_width(fmode);
    if (int'(w_width) >= FETCH_W) w_load_mask = '1;
    else                          w_load_mask = ~({FETCH_W{1'b1}} >> w_width);
  end

  // A plane-0 write re-arms even when it collides with the transfer it triggers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_arm <= 1'b0;
    else if (w_wr_plane0) r_arm <= 1'b1;
    else if (w_transfer)  r_arm <= 1'b0;
  end

  assign load_pending = r_arm;

  for (genvar p = 0; p < PLANES; p++) begin : g_lane
    logic w_lane_wr;
    assign w_lane_wr = w_wr_valid && (wr_plane == 3'(p));

    denise_plane_lane #(
      .FETCH_W  (FETCH_W),
      .OUT_DELAY(OUT_DELAY)
    ) u_lane (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_wr       (w_lane_wr),
      .i_wr_data  (wr_data),
      .i_load     (w_transfer),
      .i_load_mask(w_load_mask),
      .i_shift    (w_shift),
      .i_select   ((p % 2 == 0) ? w_sel_odd : w_sel_even),
      .o_pix      (pix_out[p])
    );
  end

endmodule

// File: tb/tb_denise_playfield_serializer.sv
// Bench for denise_playfield_serializer: cycle scoreboard against a behavioural
// model, a table of scroll/fmode vectors and hand-written corner sequences.
module tb_denise_playfield_serializer;

  localparam int PLANES    = 8;
  localparam int FETCH_W   = 64;
  localparam int OUT_DELAY = 4;
  localparam int W         = PLANES + 1;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] B47  = 64'h0000_8000_0000_0000;
  localparam logic [63:0] TOP16 = 64'hFFFF_0000_0000_0000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               c1 = 1'b0;
  logic               c3 = 1'b0;
  logic               hires = 1'b0;
  logic               shres = 1'b0;
  logic [1:0]         fmode = 2'b00;
  logic               wr_en = 1'b0;
  logic [2:0]         wr_plane = 3'd0;
  logic [FETCH_W-1:0] wr_data = '0;
  logic [7:0]         scroll_odd = 8'h00;
  logic [7:0]         scroll_even = 8'h00;
  logic               load_pending;
  logic [PLANES-1:0]  pix_out;

  denise_playfield_serializer #(
    .PLANES(PLANES), .FETCH_W(FETCH_W), .OUT_DELAY(OUT_DELAY)
  ) dut (
    .clk(clk), .reset(reset), .c1(c1), .c3(c3), .hires(hires), .shres(shres),
    .fmode(fmode), .wr_en(wr_en), .wr_plane(wr_plane), .wr_data(wr_data),
    .scroll_odd(scroll_odd), .scroll_even(scroll_even),
    .load_pending(load_pending), .pix_out(pix_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0] ph = 2'd0;
  logic [W-1:0] exp_q[$];

  // behavioural model state
  logic [63:0]          m_hold[PLANES];
  logic [63:0]          m_sh[PLANES];
  logic [63:0]          m_scr[PLANES];
  logic [OUT_DELAY-1:0] m_dly[PLANES];
  logic                 m_arm;

  typedef struct {
    logic [1:0]  res;
    logic [1:0]  fm;
    logic [7:0]  so;
    logic [7:0]  se;
    logic [63:0] d1;
    int          t0;
    int          t1_oe;
    int          t1_sh;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < PLANES; p++) begin
      m_hold[p] = '0; m_sh[p] = '0; m_scr[p] = '0; m_dly[p] = '0;
    end
    m_arm = 1'b0;
  endtask

  function automatic int scroll_index(input logic [7:0] s, input int w);
    int raw = int'(s);
    if (shres)      return raw % w;
    else if (hires) return (raw / 2) % w;
    else            return (raw / 4) % w;
  endfunction

  task automatic model_step();
    logic slot, xfer, sh, tap;
    int w, io, ie, idx;
    logic [63:0] mask;
    if (reset) begin
      model_clear();
      return;
    end
    slot = !c1 && !c3;
    xfer = m_arm && slot;
    w = (fmode == 2'b00) ? 16 : (fmode == 2'b11) ? 64 : 32;
    mask = (w == 64) ? {64{1'b1}} : ({64{1'b1}} << (64 - w));
    if (shres)      sh = 1'b1;
    else if (hires) sh = (c1 == c3);
    else            sh = slot;
    io = scroll_index(scroll_odd, w);
`ifdef DENISE_SERIALIZER_ODD_EVEN_SCROLL_EN
    ie = scroll_index(scroll_even, w);
`else
    ie = io;
`endif
    for (int p = 0; p < PLANES; p++) begin
      idx = (p % 2 == 0) ? io : ie;
      tap = m_scr[p][idx];
      m_dly[p] = {m_dly[p][OUT_DELAY-2:0], tap};
      if (sh) m_scr[p] = {m_scr[p][62:0], m_sh[p][63]};
      if (xfer)    m_sh[p] = m_hold[p] & mask;
      else if (sh) m_sh[p] = m_sh[p] << 1;
    end
    if (wr_en) m_hold[wr_plane] = wr_data;
    if (wr_en && wr_plane == 3'd0) m_arm = 1'b1;
    else if (xfer)                 m_arm = 1'b0;
  endtask

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] v;
    v[PLANES] = m_arm;
    for (int p = 0; p < PLANES; p++) v[p] = m_dly[p][OUT_DELAY-1];
    return v;
  endfunction

  // One pixel clock: drive phases, predict, clock, then score on the falling edge.
  task automatic cycle();
    logic [W-1:0] e, a;
    c1 = ph[1];
    c3 = ph[1] ^ ph[0];
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    ph = ph + 2'd1;
    @(negedge clk);
    e = exp_q.pop_front();
    a = {load_pending, pix_out};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_out: got %0h expected %0h at %0t", a, e, $time);
    end
  endtask

  task automatic write_plane(input logic [2:0] plane, input logic [63:0] data);
    wr_en = 1'b1; wr_plane = plane; wr_data = data;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic wait_phase(input logic [1:0] target);
    for (int n = 0; n < 4 && ph != target; n++) cycle();
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_pix", 64'(pix_out), 64'd0);
    check("reset_lp", 64'(load_pending), 64'd0);
    model_clear();
    @(negedge clk);
    cycle();
    reset = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] res, input logic [1:0] fm,
                          input logic [7:0] so, input logic [7:0] se);
    hires = (res == 2'd1);
    shres = (res == 2'd2);
    fmode = fm;
    scroll_odd = so;
    scroll_even = se;
  endtask

  initial begin
    int t0, t1, ones0, ones1, lp_hi, nz, exp_t1;

    vecs[0]  = '{2'd0, 2'd0, 8'h00, 8'h00, MSB, 11,  11, 11};
    vecs[1]  = '{2'd0, 2'd0, 8'h08, 8'h00, MSB, 19,  11, 19};
    vecs[2]  = '{2'd1, 2'd0, 8'h08, 8'h00, MSB, 17,   9, 17};
    vecs[3]  = '{2'd2, 2'd0, 8'h08, 8'h00, MSB, 16,   8, 16};
    vecs[4]  = '{2'd0, 2'd0, 8'h00, 8'h04, MSB, 11,  15, 11};
    vecs[5]  = '{2'd0, 2'd0, 8'hFC, 8'h00, MSB, 71,  11, 71};
    vecs[6]  = '{2'd0, 2'd3, 8'hFC, 8'h00, MSB, 263, 11, 263};
    vecs[7]  = '{2'd0, 2'd1, 8'h00, 8'h00, B47, 11,  75, 75};
    vecs[8]  = '{2'd0, 2'd0, 8'h00, 8'h00, B47, 11,  -1, -1};
    vecs[9]  = '{2'd2, 2'd2, 8'h3F, 8'h21, MSB, 39,   9, 39};
    vecs[10] = '{2'd1, 2'd3, 8'hFE, 8'h02, MSB, 135, 11, 135};

    model_clear();
    @(negedge clk);
    check("por_pix", 64'(pix_out), 64'd0);
    check("por_lp", 64'(load_pending), 64'd0);
    cycle();
    reset = 1'b0;

    // hold and transfer
    do_reset();
    set_mode(2'd0, 2'b00, 8'h00, 8'h00);
    write_plane(3'd1, TOP16);
    wait_phase(2'd1);
    write_plane(3'd0, MSB);
    check("arm_after_wr0", 64'(load_pending), 64'd1);
    ones0 = 0; ones1 = 0; lp_hi = 0;
    for (int k = 1; k < 200; k++) begin
      cycle();
      ones0 += int'(pix_out[0]);
      ones1 += int'(pix_out[1]);
      lp_hi += int'(load_pending);
    end
    check("xfer_lp_cycles", 64'(lp_hi), 64'd2);
    check("xfer_plane0_ones", 64'(ones0), 64'd4);
    check("xfer_plane1_ones", 64'(ones1), 64'd64);

    // no arm without a plane-0 write
    do_reset();
    write_plane(3'd3, {64{1'b1}});
    lp_hi = 0; nz = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      lp_hi += int'(load_pending);
      nz += (pix_out != '0) ? 1 : 0;
    end
    check("noarm_lp", 64'(lp_hi), 64'd0);
    check("noarm_pix", 64'(nz), 64'd0);

    // plane-0 write colliding with its own transfer
    do_reset();
    set_mode(2'd0, 2'b00, 8'h00, 8'h00);
    wait_phase(2'd1);
    write_plane(3'd0, MSB);
    cycle();
    cycle();
    check("collide_phase", 64'(ph), 64'd0);
    write_plane(3'd0, 64'hE000_0000_0000_0000);
    check("collide_arm_kept", 64'(load_pending), 64'd1);
    for (int k = 0; k < 4; k++) cycle();
    check("collide_arm_cleared", 64'(load_pending), 64'd0);
    for (int k = 0; k < 80; k++) cycle();

    // scroll / fmode / odd-even vectors
    for (int i = 0; i < 11; i++) begin
      do_reset();
      set_mode(vecs[i].res, vecs[i].fm, vecs[i].so, vecs[i].se);
      write_plane(3'd1, vecs[i].d1);
      wait_phase(2'd1);
      write_plane(3'd0, MSB);
      t0 = pix_out[0] ? 0 : -1;
      t1 = pix_out[1] ? 0 : -1;
      for (int k = 1; k < 300; k++) begin
        cycle();
        if (t0 < 0 && pix_out[0]) t0 = k;
        if (t1 < 0 && pix_out[1]) t1 = k;
      end
`ifdef DENISE_SERIALIZER_ODD_EVEN_SCROLL_EN
      exp_t1 = vecs[i].t1_oe;
`else
      exp_t1 = vecs[i].t1_sh;
`endif
      check($sformatf("vec%0d_t0", i), 64'(t0), 64'(vecs[i].t0));
      check($sformatf("vec%0d_t1", i), 64'(t1), 64'(exp_t1));
    end

    // reset mid-line with data flowing and a transfer armed
    do_reset();
    set_mode(2'd0, 2'b00, 8'h00, 8'h00);
    write_plane(3'd1, TOP16);
    write_plane(3'd0, TOP16);
    for (int k = 0; k < 20; k++) cycle();
    write_plane(3'd0, TOP16);
    check("midline_pix_before", 64'(pix_out[0]), 64'd1);
    do_reset();
    lp_hi = 0; nz = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      lp_hi += int'(load_pending);
      nz += (pix_out != '0) ? 1 : 0;
    end
    check("post_reset_lp", 64'(lp_hi), 64'd0);
    check("post_reset_pix", 64'(nz), 64'd0);
    write_plane(3'd0, TOP16);
    ones0 = 0; ones1 = 0;
    for (int k = 0; k < 120; k++) begin
      cycle();
      ones0 += int'(pix_out[0]);
      ones1 += int'(pix_out[1]);
    end
    check("post_reset_plane0_ones", 64'(ones0), 64'd64);
    check("post_reset_plane1_ones", 64'(ones1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
